// File: rtl/char_deserializer.sv
// char_deserializer: bit-serial, MSB-first 8-bit character receiver.
// Completed characters are queued in a small circular FIFO and presented
// downstream on a valid/ready handshake.
// Optional feature: define CHAR_DESER_LOWER_FLAG_EN to decode out_lower
// ('a'..'z' head character). When it is undefined, out_lower is tied low.
module char_deserializer #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sin_valid,
   input  logic          sin_bit,
   input  logic          sin_sync,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_char,
   output logic          out_lower,
   output logic [CW-1:0] level,
   output logic          overflow
);

   localparam int AW = $clog2(DEPTH);

   // The eighth bit of a character comes straight from sin_bit, so only the
   // seven most recent bits ever need to be held.
   logic [6:0]    sr_r;
   logic [2:0]    bcnt_r;
   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] level_r;
   logic          overflow_r;

   logic          bit_acc_s;
   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic          push_ok_s;
   logic [7:0]    char_s;

   // Handshake and push/pop decisions for the current cycle.
   always_comb begin
      bit_acc_s = sin_valid & ~sin_sync;
      char_s    = {sr_r, sin_bit};
      push_s    = 1'b0;
      if (bit_acc_s && (bcnt_r == 3'd7)) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
      full_s    = (level_r == CW'(DEPTH));
      pop_s     = (level_r != {CW{1'b0}}) & out_ready;
      // When full, a push only fits if the head leaves in the same cycle.
      push_ok_s = push_s & (~full_s | pop_s);
   end

   // Serial shift register and bit counter; sync realigns the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_r   <= 7'd0;
         bcnt_r <= 3'd0;
      end else if (sin_sync) begin
         bcnt_r <= 3'd0;
      end else if (sin_valid) begin
         sr_r   <= {sr_r[5:0], sin_bit};
         bcnt_r <= bcnt_r + 3'd1;
      end
   end

   // FIFO storage; cleared on reset so the idle head reads as 0x00.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= char_s;
      end
   end

   // FIFO pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         level_r    <= {CW{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         if (push_s && !push_ok_s) begin
            overflow_r <= 1'b1;
         end
         case ({push_ok_s, pop_s})
            2'b10:   level_r <= level_r + CW'(1);
            2'b01:   level_r <= level_r - CW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   assign out_valid = (level_r != {CW{1'b0}});
   assign out_char  = mem_r[rd_ptr_r];
   assign level     = level_r;
   assign overflow  = overflow_r;

`ifdef CHAR_DESER_LOWER_FLAG_EN
   assign out_lower = (out_char >= 8'h61) && (out_char <= 8'h7A);
`else
   assign out_lower = 1'b0;
`endif

endmodule
